// File: rtl/z_core_mdu.sv
// rtl/z_core_mdu.sv - Z-Core RV32M iterative multiply/divide unit (optional Z_CORE_MDU_FAST_EN: early finish for divide-by-zero and signed overflow)
module z_core_mdu #(
    parameter int CYCLES = 32 // one iteration per operand bit; must stay 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mdu_in1,
    input  logic [31:0] mdu_in2,
    input  logic [2:0]  mdu_op,
    input  logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] mdu_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, FINAL = 2'd2} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] prod;     // multiply: {partial sum, multiplier}; divide: {remainder, dividend/quotient}
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic        div_ovf;

    // Operand decode at accept time: signedness per op, magnitudes, special cases
    logic        sgn_a, sgn_b, in1_neg, in2_neg, zero_in, ovf_in;
    logic [31:0] in1_mag, in2_mag;

    always_comb begin
        sgn_a   = (mdu_op == 3'd1) || (mdu_op == 3'd2) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
        sgn_b   = (mdu_op == 3'd1) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
        in1_neg = sgn_a & mdu_in1[31];
        in2_neg = sgn_b & mdu_in2[31];
        in1_mag = in1_neg ? (~mdu_in1 + 32'd1) : mdu_in1;
        in2_mag = in2_neg ? (~mdu_in2 + 32'd1) : mdu_in2;
        zero_in = mdu_op[2] && (mdu_in2 == 32'd0);
        ovf_in  = mdu_op[2] && !mdu_op[0] && (mdu_in1 == 32'h8000_0000) && (mdu_in2 == 32'hFFFF_FFFF);
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [33:0] div_diff;
    logic [63:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
        mul_next  = {mul_sum, prod[31:1]};
        div_trial = {prod[63:32], prod[31]};
        div_diff  = {1'b0, div_trial} - {2'b00, b_mag};
        if (!div_diff[33]) begin
            div_next = {div_diff[31:0], prod[30:0], 1'b1};
        end else begin
            div_next = {div_trial[31:0], prod[30:0], 1'b0};
        end
    end

    // Sign fixup and result selection used in the FINAL cycle
    logic        sign_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, dividend, result;

    always_comb begin
        sign_diff = neg_a ^ neg_b;
        prod_fix  = sign_diff ? (~prod + 64'd1) : prod;
        quo_fix   = sign_diff ? (~prod[31:0] + 32'd1) : prod[31:0];
        rem_fix   = neg_a ? (~prod[63:32] + 32'd1) : prod[63:32];
        dividend  = neg_a ? (~a_mag + 32'd1) : a_mag;
        result    = 32'd0;
        case (op_q)
            3'd0:                result = prod_fix[31:0];
            3'd1, 3'd2, 3'd3:    result = prod_fix[63:32];
            3'd4, 3'd5: begin
                if (div_zero)     result = 32'hFFFF_FFFF;
                else if (div_ovf) result = 32'h8000_0000;
                else              result = quo_fix;
            end
            default: begin
                if (div_zero)     result = dividend;
                else if (div_ovf) result = 32'd0;
                else              result = rem_fix;
            end
        endcase
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            op_q     <= 3'd0;
            a_mag    <= 32'd0;
            b_mag    <= 32'd0;
            prod     <= 64'd0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            mdu_busy <= 1'b0;
            mdu_done <= 1'b0;
            mdu_out  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    mdu_done <= 1'b0;
                    if (mdu_start) begin
                        op_q     <= mdu_op;
                        a_mag    <= in1_mag;
                        b_mag    <= in2_mag;
                        neg_a    <= in1_neg;
                        neg_b    <= in2_neg;
                        div_zero <= zero_in;
                        div_ovf  <= ovf_in;
                        prod     <= mdu_op[2] ? {32'd0, in1_mag} : {32'd0, in2_mag};
                        cnt      <= 5'd0;
                        mdu_busy <= 1'b1;
`ifdef Z_CORE_MDU_FAST_EN
                        state    <= (zero_in || ovf_in) ? FINAL : EXEC;
`else
                        state    <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    prod <= op_q[2] ? div_next : mul_next;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(CYCLES - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    mdu_out  <= result;
                    mdu_done <= 1'b1;
                    mdu_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/z_core_mdu.md
Name: z_core_mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M operations for Z-Core.
- Sits beside the combinational z_core_alu in the execute stage and uses the same operand/result style (in1/in2/op in, 32-bit out).
- Adds a start/busy/done handshake so the core control FSM can stall while the result is computed over multiple cycles.

Parameters:
- CYCLES, 32, iterations per operation; must equal the operand width of 32 (radix-2, one bit per cycle).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mdu_in1  input  32  operand 1 (multiplicand / dividend); sampled only on an accepted start.
- mdu_in2  input  32  operand 2 (multiplier / divisor); sampled only on an accepted start.
- mdu_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- mdu_start  input  1  request; accepted only when state is IDLE.
- mdu_busy  output  1  high from the accept edge until the result is registered.
- mdu_done  output  1  single-cycle pulse; mdu_out is valid in that cycle.
- mdu_out  output  32  result; holds its value until the next result is registered.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, mdu_busy=0, mdu_done=0, mdu_out=0, iteration counter=0.
  - Any partial result is discarded.
- States: IDLE -> EXEC -> FINAL -> IDLE.
- IDLE:
  - mdu_start=1 at edge E0: latch operand magnitudes, sign flags (per op signedness) and op; counter=0; busy=1; go to EXEC.
  - mdu_start=0: stay in IDLE.
- EXEC, edges E1..E32, one iteration per edge, counter increments 0..31:
  - MUL*: shift-add on unsigned magnitudes into a 64-bit product register.
  - DIV*/REM*: restoring division on magnitudes; 32-bit quotient and remainder.
  - At counter=31, go to FINAL.
- FINAL, edge E33:
  - Apply sign fixup: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Select output: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register mdu_out, set done=1, busy=0, go to IDLE.
- Latency: done is high during the cycle after E33 (33 edges after accept) and drops after E34 unless a new result completes.
- Signedness:
  - MULH treats both operands as signed.
  - MULHSU treats in1 as signed, in2 as unsigned.
  - MULHU, DIVU, REMU treat both as unsigned.
- Divide by zero, all divide/remainder ops: quotient=0xFFFFFFFF; remainder=dividend (unmodified).
- Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- mdu_start while busy: ignored, no effect on the in-flight operation or on the latched operands.
- Back-to-back: start asserted in the same cycle as done is accepted at that edge (state is IDLE); done falls and busy rises at that edge.
- Operand inputs may change freely after the accept edge.

Optional Feature:
- Macro: Z_CORE_MDU_FAST_EN.
- Defined:
  - Divide by zero and signed overflow skip EXEC: IDLE goes directly to FINAL at E0.
  - Result registered at E1; done high in the cycle after E1.
  - All other operations keep 33-edge latency.
- Undefined: every operation, special cases included, takes exactly 33 edges; special-case results are identical in both builds.

Test Plan:
- MUL in1=7, in2=0xFFFFFFFD (-3) -> mdu_out=0xFFFFFFEB; done exactly 33 edges after accept; busy high 33 cycles; done one cycle wide.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
- REM same operands -> 0xFFFFFFFF.
- DIVU 100/7 -> 14.
- REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM 0x80000000/0xFFFFFFFF -> 0.
- Latency of the special-case operations: 33 edges without Z_CORE_MDU_FAST_EN, 1 edge with it.
- Start MUL 3*4; pulse start with different operands at E10 -> ignored, result 12 at E33.
- Start asserted in the done cycle is accepted; second result appears 33 edges later.
- Assert rst at E15 of a DIV -> busy=0, done=0, mdu_out=0 immediately (async).
- After reset release, a new MUL 6*7 -> 42 with normal latency.
